mc_controller_v2: RTL and testbench
===================================

Name: mc_controller_v2

Overview:
- Next-generation multicycle MIPS control unit: a Moore main-decode FSM, a combinational ALU-function decoder, and PC-enable logic.
- New over the previous controller:
  - Memory ready/request handshake, so fetch and load/store states stall on slow memory.
  - Four branch conditions: beq, bne, blez, bgtz.
  - Sub-word load/store size codes.
  - Illegal-opcode exception state.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- STATE_W, 5: width of the state output. Must be >= 4.
- ACW, 3: alucontrol width. Must be >= 3.
- MEM_HANDSHAKE, 1: 1 = wait on memready. 0 = memready ignored, treated as 1.
- EXC_EN, 1: 1 = illegal opcode enters EXC. 0 = illegal opcode returns to FETCH as a NOP.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  instruction opcode (IR[31:26])
- funct  in  6  R-type function field (IR[5:0])
- zero  in  1  ALU result == 0
- neg  in  1  ALU result sign bit
- memready  in  1  memory completes the current access this cycle
- memreq  out  1  memory access requested
- pcen  out  1  PC register enable
- memwrite  out  2  store size: 00 none, 01 byte, 10 half, 11 word
- irwrite, regwrite, iord, memtoreg, regdst, alusrca, epcwrite, excpt  out  1 each  datapath strobes/selects
- alusrcb  out  3  B-operand select: 000 rd2, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm
- pcsrc  out  2  next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 exception vector
- alucontrol  out  ACW  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- ltype  out  2  load size: 00 word, 01 byte signed, 10 half signed, 11 unsigned (size taken from op[0])
- state  out  STATE_W  current state code, zero-extended

Behaviour:
- States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BREX=8, IEX=9, IWB=10, JEX=11, EXC=12.
- Reset (reset==0): state=FETCH immediately. All outputs are 0 while reset is held.
- Outputs are a decode of state. The write strobes in memory states are additionally gated by memready.
- FETCH:
  - Outputs: memreq=1, iord=0, alusrca=0, alusrcb=001, pcsrc=00, alucontrol=add.
  - irwrite=pcwrite=memready.
  - Stays in FETCH while memready=0. Goes to DECODE when memready=1.
- DECODE:
  - alusrcb=011, alucontrol=add (branch-target precompute).
  - Next state by op:
    - 100011/100000/100100/100001/100101/101011/101000/101001 -> MEMADR
    - 000000 -> RTEX
    - 000100..000111 -> BREX
    - 001000/001010/001100/001101 -> IEX
    - 000010 -> JEX
    - anything else -> EXC (EXC_EN=1) or FETCH (EXC_EN=0)
- MEMADR: alusrca=1, alusrcb=010, add. Loads -> MEMRD, stores -> MEMWR.
- MEMRD:
  - memreq=1, iord=1.
  - ltype: op 100011->00, 100000->01, 100001->10, 100100/100101->11.
  - Advances to MEMWB on memready, otherwise holds.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, ltype held from MEMRD. Next FETCH.
- MEMWR:
  - memreq=1, iord=1.
  - memwrite = size code (101011->11, 101001->10, 101000->01) only while memready=1, else 00.
  - FETCH on memready, otherwise holds.
- RTEX: alusrca=1, alusrcb=000, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; others add.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BREX:
  - alusrca=1, alusrcb=000, sub, pcsrc=01, branch=1. Next FETCH.
  - Condition cond: beq zero, bne ~zero, blez neg|zero, bgtz ~neg&~zero.
- IEX: alusrca=1. addi add/010, slti slt/010, andi and/100, ori or/100 (alucontrol/alusrcb). IWB: regwrite=1, regdst=0. Next FETCH.
- JEX: pcsrc=10, pcwrite=1. Next FETCH.
- EXC: epcwrite=1, excpt=1, pcsrc=11, pcwrite=1, for exactly one cycle. Next FETCH.
- PC enable: pcen = pcwrite | (branch & cond).
- Latency with memready always 1: lw 5 cycles, sw 4, R-type 4, imm 4, branch 3, j 3, illegal 3. Each memory wait cycle adds 1.
- An async reset asserted mid-access aborts it. No partial writes persist beyond the reset cycle.
- memready=1 in a non-memory state is ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum.
  - Opcode and funct localparams.
  - alusrcb, pcsrc, ltype and memwrite code constants.
  - ALU function codes.
- Sub-module mc_alu_decoder (combinational): {state-derived aluop, funct} -> alucontrol.
- FSM and pcen logic stay in the top.

Test Plan:
- Reset held low, then released; memready=1 -> state=0 and all outputs 0 during reset; first cycle after release shows memreq=1, irwrite=1, pcen=1.
- lw (op=100011), memready low for 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4,0; ltype=00; regwrite high only in state 4.
- sh (op=101001), memready=0 then 1 in MEMWR -> memwrite=00 then 10; no memwrite outside that one cycle.
- Branches in BREX: bgtz with neg=0, zero=0 -> pcen=1, pcsrc=01; blez with neg=0, zero=0 -> pcen=0; bne with zero=1 -> pcen=0.
- R-type funct=101010 -> alucontrol=111 in RTEX; regdst=1 and regwrite=1 in RTWB.
- op=111111 with EXC_EN=1 -> state 12 for one cycle with epcwrite=1, pcsrc=11, pcen=1; with EXC_EN=0 -> DECODE goes straight to FETCH with no strobes.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, datapath select codes and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BREX   = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JEX    = 4'd11,
    S_EXC    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'd0,
    AOP_SUB   = 3'd1,
    AOP_FUNCT = 3'd2,
    AOP_SLT   = 3'd3,
    AOP_AND   = 3'd4,
    AOP_OR    = 3'd5
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] SRCB_RD2     = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIGNIMM = 3'b010;
  localparam logic [2:0] SRCB_BRANCH  = 3'b011;
  localparam logic [2:0] SRCB_ZEROIMM = 3'b100;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  localparam logic [1:0] PCSRC_EXC  = 2'b11;

  localparam logic [1:0] LT_WORD  = 2'b00;
  localparam logic [1:0] LT_BYTE  = 2'b01;
  localparam logic [1:0] LT_HALF  = 2'b10;
  localparam logic [1:0] LT_UNSGN = 2'b11;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LH) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [1:0] ltype_of(input logic [5:0] op);
    case (op)
      OP_LB:         return LT_BYTE;
      OP_LH:         return LT_HALF;
      OP_LBU, OP_LHU: return LT_UNSGN;
      default:       return LT_WORD;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input logic [5:0] op);
    case (op)
      OP_SW:   return MW_WORD;
      OP_SH:   return MW_HALF;
      OP_SB:   return MW_BYTE;
      default: return MW_NONE;
    endcase
  endfunction

  // Branch outcome from the ALU flags of rs - rt (beq/bne) or rs - 0 (blez/bgtz).
  function automatic logic branch_cond(input logic [5:0] op, input logic zero,
                                       input logic neg);
    case (op)
      OP_BEQ:  return zero;
      OP_BNE:  return ~zero;
      OP_BLEZ: return neg | zero;
      OP_BGTZ: return ~neg & ~zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_v2_alu_decoder.sv
// Combinational ALU-function decoder: state-derived ALU operation plus the
// R-type funct field select the ALU control code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ACW = 3
) (
  input  aluop_t           aluop_i,
  input  logic [5:0]       funct_i,
  output logic [ACW-1:0]   alucontrol_o
);

  logic [2:0] code_s;

  // Map operation class (and funct for R-type) to the 3-bit ALU code.
  always_comb begin
    code_s = ALU_ADD;
    case (aluop_i)
      AOP_ADD: code_s = ALU_ADD;
      AOP_SUB: code_s = ALU_SUB;
      AOP_SLT: code_s = ALU_SLT;
      AOP_AND: code_s = ALU_AND;
      AOP_OR:  code_s = ALU_OR;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  code_s = ALU_ADD;
          FN_SUB:  code_s = ALU_SUB;
          FN_AND:  code_s = ALU_AND;
          FN_OR:   code_s = ALU_OR;
          FN_SLT:  code_s = ALU_SLT;
          default: code_s = ALU_ADD;
        endcase
      end
      default: code_s = ALU_ADD;
    endcase
  end

  assign alucontrol_o = ACW'(code_s);

endmodule

// File: rtl/mc_controller_v2.sv
// Multicycle MIPS control unit: Moore main-decode FSM with memory handshake,
// four branch conditions, sub-word load/store sizing and an exception state.
module mc_controller_v2
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W       = 5,
  parameter int ACW           = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXC_EN        = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               neg,
  input  logic               memready,
  output logic               memreq,
  output logic               pcen,
  output logic [1:0]         memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic               epcwrite,
  output logic               excpt,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ACW-1:0]     alucontrol,
  output logic [1:0]         ltype,
  output logic [STATE_W-1:0] state
);

  state_t         state_q, state_d;
  aluop_t         aluop_s;
  logic           mr_s;
  logic           pcwrite_s;
  logic           branch_s;
  logic [ACW-1:0] alu_s;

  assign mr_s = (MEM_HANDSHAKE != 0) ? memready : 1'b1;

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states hold until the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mr_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_load(op) || is_store(op)) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          state_d = S_RTEX;
        end else if (op[5:2] == 4'b0001) begin
          state_d = S_BREX;
        end else if (is_imm(op)) begin
          state_d = S_IEX;
        end else if (op == OP_J) begin
          state_d = S_JEX;
        end else begin
          state_d = (EXC_EN != 0) ? S_EXC : S_FETCH;
        end
      end
      S_MEMADR: state_d = is_store(op) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mr_s ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mr_s ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BREX:   state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JEX:    state_d = S_FETCH;
      S_EXC:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; write strobes in memory states wait for memready.
  always_comb begin
    memreq    = 1'b0;
    memwrite  = MW_NONE;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    epcwrite  = 1'b0;
    excpt     = 1'b0;
    alusrcb   = SRCB_RD2;
    pcsrc     = PCSRC_ALU;
    ltype     = LT_WORD;
    aluop_s   = AOP_ADD;
    pcwrite_s = 1'b0;
    branch_s  = 1'b0;
    if (!reset) begin
      memreq = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          memreq    = 1'b1;
          alusrcb   = SRCB_FOUR;
          irwrite   = mr_s;
          pcwrite_s = mr_s;
        end
        S_DECODE: alusrcb = SRCB_BRANCH;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_SIGNIMM;
        end
        S_MEMRD: begin
          memreq = 1'b1;
          iord   = 1'b1;
          ltype  = ltype_of(op);
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          ltype    = ltype_of(op);
        end
        S_MEMWR: begin
          memreq   = 1'b1;
          iord     = 1'b1;
          memwrite = mr_s ? store_size(op) : MW_NONE;
        end
        S_RTEX: begin
          alusrca = 1'b1;
          aluop_s = AOP_FUNCT;
        end
        S_RTWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BREX: begin
          alusrca  = 1'b1;
          aluop_s  = AOP_SUB;
          pcsrc    = PCSRC_OUT;
          branch_s = 1'b1;
        end
        S_IEX: begin
          alusrca = 1'b1;
          case (op)
            OP_SLTI: begin aluop_s = AOP_SLT; alusrcb = SRCB_SIGNIMM; end
            OP_ANDI: begin aluop_s = AOP_AND; alusrcb = SRCB_ZEROIMM; end
            OP_ORI:  begin aluop_s = AOP_OR;  alusrcb = SRCB_ZEROIMM; end
            default: begin aluop_s = AOP_ADD; alusrcb = SRCB_SIGNIMM; end
          endcase
        end
        S_IWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc     = PCSRC_JUMP;
          pcwrite_s = 1'b1;
        end
        S_EXC: begin
          epcwrite  = 1'b1;
          excpt     = 1'b1;
          pcsrc     = PCSRC_EXC;
          pcwrite_s = 1'b1;
        end
        default: memreq = 1'b0;
      endcase
    end
  end

  mc_alu_decoder #(.ACW(ACW)) u_alu_dec (
    .aluop_i      (aluop_s),
    .funct_i      (funct),
    .alucontrol_o (alu_s)
  );

  assign alucontrol = reset ? alu_s : {ACW{1'b0}};
  assign pcen       = pcwrite_s | (branch_s & branch_cond(op, zero, neg));
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller_v2.sv
// Self-checking bench: an instruction-level path model predicts the state
// walk and per-state outputs; directed checks pin key values of that model.
module tb_mc_controller_v2;

  typedef struct packed {
    logic [4:0] state;
    logic       memreq;
    logic       pcen;
    logic [1:0] memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic       epcwrite;
    logic       excpt;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [1:0] ltype;
  } obs_t;

  logic clk = 1'b0;
  logic reset, reset2;
  logic [5:0] op, funct;
  logic zero, neg, memready;

  logic [4:0] a_state, b_state;
  logic a_memreq, a_pcen, a_irwrite, a_regwrite, a_iord, a_memtoreg, a_regdst, a_alusrca, a_epcwrite, a_excpt;
  logic b_memreq, b_pcen, b_irwrite, b_regwrite, b_iord, b_memtoreg, b_regdst, b_alusrca, b_epcwrite, b_excpt;
  logic [1:0] a_memwrite, b_memwrite, a_pcsrc, b_pcsrc, a_ltype, b_ltype;
  logic [2:0] a_alusrcb, b_alusrcb, a_alucontrol, b_alucontrol;

  always #5 clk = ~clk;

  mc_controller_v2 #(.STATE_W(5), .ACW(3), .MEM_HANDSHAKE(1), .EXC_EN(1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .neg(neg),
    .memready(memready), .memreq(a_memreq), .pcen(a_pcen), .memwrite(a_memwrite),
    .irwrite(a_irwrite), .regwrite(a_regwrite), .iord(a_iord), .memtoreg(a_memtoreg),
    .regdst(a_regdst), .alusrca(a_alusrca), .epcwrite(a_epcwrite), .excpt(a_excpt),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .alucontrol(a_alucontrol), .ltype(a_ltype),
    .state(a_state));

  mc_controller_v2 #(.STATE_W(5), .ACW(3), .MEM_HANDSHAKE(1), .EXC_EN(0)) u_dut_noexc (
    .clk(clk), .reset(reset2), .op(op), .funct(funct), .zero(zero), .neg(neg),
    .memready(memready), .memreq(b_memreq), .pcen(b_pcen), .memwrite(b_memwrite),
    .irwrite(b_irwrite), .regwrite(b_regwrite), .iord(b_iord), .memtoreg(b_memtoreg),
    .regdst(b_regdst), .alusrca(b_alusrca), .epcwrite(b_epcwrite), .excpt(b_excpt),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .alucontrol(b_alucontrol), .ltype(b_ltype),
    .state(b_state));

  obs_t obs_a, obs_b;
  assign obs_a = '{state:a_state, memreq:a_memreq, pcen:a_pcen, memwrite:a_memwrite,
                   irwrite:a_irwrite, regwrite:a_regwrite, iord:a_iord, memtoreg:a_memtoreg,
                   regdst:a_regdst, alusrca:a_alusrca, epcwrite:a_epcwrite, excpt:a_excpt,
                   alusrcb:a_alusrcb, pcsrc:a_pcsrc, alucontrol:a_alucontrol, ltype:a_ltype};
  assign obs_b = '{state:b_state, memreq:b_memreq, pcen:b_pcen, memwrite:b_memwrite,
                   irwrite:b_irwrite, regwrite:b_regwrite, iord:b_iord, memtoreg:b_memtoreg,
                   regdst:b_regdst, alusrca:b_alusrca, epcwrite:b_epcwrite, excpt:b_excpt,
                   alusrcb:b_alusrcb, pcsrc:b_pcsrc, alucontrol:b_alucontrol, ltype:b_ltype};

  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  bit   sel_b = 1'b0;
  int   exp_st = 0;
  obs_t hist [0:15];
  int   hn = 0;

  // What the controller must show in a given state, straight from the state table.
  function automatic obs_t exp_out(input int st, input bit in_rst, input logic [5:0] o,
                                   input logic [5:0] f, input logic z, input logic n,
                                   input logic mr);
    obs_t e;
    e = '0;
    if (in_rst) return e;
    e.state = 5'(st);
    e.alucontrol = 3'b010;
    case (st)
      0: begin e.memreq = 1'b1; e.alusrcb = 3'b001; e.irwrite = mr; e.pcen = mr; end
      1: e.alusrcb = 3'b011;
      2: begin e.alusrca = 1'b1; e.alusrcb = 3'b010; end
      3, 4: begin
        if (st == 3) begin e.memreq = 1'b1; e.iord = 1'b1; end
        else begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
        e.ltype = (o == 6'b100000) ? 2'b01 : (o == 6'b100001) ? 2'b10 :
                  (o == 6'b100100 || o == 6'b100101) ? 2'b11 : 2'b00;
      end
      5: begin
        e.memreq = 1'b1; e.iord = 1'b1;
        if (mr) e.memwrite = (o == 6'b101011) ? 2'b11 : (o == 6'b101001) ? 2'b10 : 2'b01;
      end
      6: begin
        e.alusrca = 1'b1;
        e.alucontrol = (f == 6'b100010) ? 3'b110 : (f == 6'b100100) ? 3'b000 :
                       (f == 6'b100101) ? 3'b001 : (f == 6'b101010) ? 3'b111 : 3'b010;
      end
      7: begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      8: begin
        e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (o == 6'd4) ? z : (o == 6'd5) ? !z : (o == 6'd6) ? (n || z) : (!n && !z);
      end
      9: begin
        e.alusrca = 1'b1;
        e.alusrcb = (o == 6'b001100 || o == 6'b001101) ? 3'b100 : 3'b010;
        e.alucontrol = (o == 6'b001010) ? 3'b111 : (o == 6'b001100) ? 3'b000 :
                       (o == 6'b001101) ? 3'b001 : 3'b010;
      end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      12: begin e.epcwrite = 1'b1; e.excpt = 1'b1; e.pcsrc = 2'b11; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Per-cycle comparison of the selected DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      obs_t act, exp_v;
      act   = sel_b ? obs_b : obs_a;
      exp_v = exp_out(exp_st, sel_b ? !reset2 : !reset, op, funct, zero, neg, memready);
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t op=%b st=%0d: got %h expected %h", $time, op, exp_st, act, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // One clock cycle in the given expected state, with memready driven as given.
  task automatic step(input int st, input logic mr);
    memready = mr;
    exp_st = st;
    @(negedge clk);
    if (hn < 16) hist[hn] = sel_b ? obs_b : obs_a;
    hn++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input logic n, input int fwait, input int dwait);
    int path[$];
    op = o; funct = f; zero = z; neg = n; hn = 0;
    path = '{0, 1};
    if (o inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101}) path.push_back(2);
    if (o inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101}) path.push_back(3);
    if (o inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101}) path.push_back(4);
    if (o inside {6'b101011, 6'b101000, 6'b101001}) begin path.push_back(2); path.push_back(5); end
    if (o == 6'b000000) begin path.push_back(6); path.push_back(7); end
    if (o inside {[6'b000100:6'b000111]}) path.push_back(8);
    if (o inside {6'b001000, 6'b001010, 6'b001100, 6'b001101}) begin path.push_back(9); path.push_back(10); end
    if (o == 6'b000010) path.push_back(11);
    if (path.size() == 2 && o != 6'b000000 && !sel_b) path.push_back(12);
    foreach (path[i]) begin
      int nw;
      nw = (path[i] == 0) ? fwait : (path[i] == 3 || path[i] == 5) ? dwait : 0;
      for (int w = 0; w < nw; w++) step(path[i], 1'b0);
      step(path[i], 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lw_seq[7];
    int cnt;
    lw_seq = '{0, 1, 2, 3, 3, 3, 4};
    reset = 1'b0; reset2 = 1'b0;
    op = 6'b0; funct = 6'b0; zero = 1'b0; neg = 1'b0; memready = 1'b1;
    chk_en = 1'b1;
    hn = 0;
    step(0, 1'b1);
    step(0, 1'b1);
    chk("reset_memreq", int'(hist[1].memreq), 0);
    chk("reset_alucontrol", int'(hist[1].alucontrol), 0);
    reset = 1'b1;

    run_instr(6'b100011, 6'b0, 1'b0, 1'b0, 0, 2);
    chk("post_reset_memreq", int'(hist[0].memreq), 1);
    chk("post_reset_irwrite", int'(hist[0].irwrite), 1);
    chk("post_reset_pcen", int'(hist[0].pcen), 1);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      chk("lw_state_seq", int'(hist[i].state), lw_seq[i]);
      cnt += int'(hist[i].regwrite);
    end
    chk("lw_regwrite_count", cnt, 1);
    chk("lw_regwrite_memwb", int'(hist[6].regwrite), 1);
    chk("lw_ltype", int'(hist[3].ltype), 0);

    run_instr(6'b101001, 6'b0, 1'b0, 1'b0, 0, 1);
    chk("sh_wait_memwrite", int'(hist[3].memwrite), 0);
    chk("sh_ready_memwrite", int'(hist[4].memwrite), 2);
    cnt = 0;
    for (int i = 0; i < 5; i++) cnt += (hist[i].memwrite != 2'b00) ? 1 : 0;
    chk("sh_memwrite_cycles", cnt, 1);

    run_instr(6'b100000, 6'b0, 1'b0, 1'b0, 1, 0);
    chk("lb_ltype", int'(hist[5].ltype), 1);
    run_instr(6'b100101, 6'b0, 1'b0, 1'b0, 0, 1);
    run_instr(6'b100001, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b101000, 6'b0, 1'b0, 1'b0, 0, 2);

    run_instr(6'b000000, 6'b101010, 1'b0, 1'b0, 0, 0);
    chk("rtype_slt_alucontrol", int'(hist[2].alucontrol), 7);
    chk("rtwb_regdst", int'(hist[3].regdst), 1);
    chk("rtwb_regwrite", int'(hist[3].regwrite), 1);
    run_instr(6'b000000, 6'b100010, 1'b0, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100101, 1'b0, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b111111, 1'b0, 1'b0, 0, 0);

    run_instr(6'b000111, 6'b0, 1'b0, 1'b0, 0, 0);
    chk("bgtz_taken_pcen", int'(hist[2].pcen), 1);
    chk("bgtz_pcsrc", int'(hist[2].pcsrc), 1);
    run_instr(6'b000110, 6'b0, 1'b0, 1'b0, 0, 0);
    chk("blez_not_taken_pcen", int'(hist[2].pcen), 0);
    run_instr(6'b000101, 6'b0, 1'b1, 1'b0, 0, 0);
    chk("bne_not_taken_pcen", int'(hist[2].pcen), 0);
    run_instr(6'b000100, 6'b0, 1'b1, 1'b0, 0, 0);
    run_instr(6'b000110, 6'b0, 1'b0, 1'b1, 0, 0);
    run_instr(6'b000111, 6'b0, 1'b0, 1'b1, 0, 0);

    run_instr(6'b001000, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b001010, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b001100, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b001101, 6'b0, 1'b0, 1'b0, 0, 0);
    run_instr(6'b000010, 6'b0, 1'b0, 1'b0, 0, 0);

    run_instr(6'b111111, 6'b0, 1'b0, 1'b0, 0, 0);
    chk("exc_state", int'(hist[2].state), 12);
    chk("exc_epcwrite", int'(hist[2].epcwrite), 1);
    chk("exc_pcsrc", int'(hist[2].pcsrc), 3);
    chk("exc_pcen", int'(hist[2].pcen), 1);

    // Reset asserted while a store waits on memory must drop the access.
    op = 6'b101011; hn = 0;
    step(0, 1'b1); step(1, 1'b1); step(2, 1'b1); step(5, 1'b0);
    reset = 1'b0;
    step(0, 1'b1);
    chk("abort_memwrite", int'(hist[4].memwrite), 0);
    chk("abort_state", int'(hist[4].state), 0);
    reset = 1'b1;
    run_instr(6'b101011, 6'b0, 1'b0, 1'b0, 0, 0);

    sel_b = 1'b1;
    reset2 = 1'b1;
    run_instr(6'b111111, 6'b0, 1'b0, 1'b0, 0, 0);
    step(0, 1'b1);
    chk("noexc_decode", int'(hist[1].state), 1);
    chk("noexc_back_to_fetch", int'(hist[2].state), 0);
    chk("noexc_decode_pcen", int'(hist[1].pcen), 0);
    chk("noexc_epcwrite", int'(hist[1].epcwrite) + int'(hist[2].epcwrite), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
